// File: rtl/pmem_types_pkg.sv
// Shared physical-memory types for the cacheline adapter: beat/line widths,
// line/beat typedefs, adapter state encoding and an address-alignment helper.
package pmem_types_pkg;

  localparam int BEAT_W  = 64;
  localparam int BEATS   = 4;
  localparam int LINE_W  = BEAT_W * BEATS;
  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 2;
  localparam int BEAT_SH = 6;   // log2(BEAT_W): beat index -> bit offset

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } adapter_state_e;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(LINE_W / 8 - 1);
  endfunction

endpackage

// File: rtl/cacheline_adapter_perf.sv
// Saturating transaction/stall counters for the cacheline adapter.
// Only instantiated when CACHELINE_ADAPTER_PERF_EN is defined.
module cacheline_adapter_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_done_i,
  input  logic        wr_done_i,
  input  logic        stall_i,
  output logic [31:0] perf_reads_o,
  output logic [31:0] perf_writes_o,
  output logic [31:0] perf_stall_o
);

  logic [31:0] reads_q, writes_q, stall_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      reads_q  <= '0;
      writes_q <= '0;
      stall_q  <= '0;
    end else begin
      if (rd_done_i) reads_q  <= sat_inc(reads_q);
      if (wr_done_i) writes_q <= sat_inc(writes_q);
      if (stall_i)   stall_q  <= sat_inc(stall_q);
    end
  end

  assign perf_reads_o  = reads_q;
  assign perf_writes_o = writes_q;
  assign perf_stall_o  = stall_q;

endmodule

// File: rtl/cacheline_adapter.sv
// Converts one 256-bit line request into a 4-beat x 64-bit memory burst and back.
// Optional performance counters are added when CACHELINE_ADAPTER_PERF_EN is defined.
module cacheline_adapter
  import pmem_types_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              line_read,
  input  logic              line_write,
  input  logic [ADDR_W-1:0] line_address,
  input  line_t             line_wdata,
  output line_t             line_rdata,
  output logic              line_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output beat_t             mem_wdata,
  input  beat_t             mem_rdata,
  input  logic              mem_resp
`ifdef CACHELINE_ADAPTER_PERF_EN
  ,
  output logic [31:0]       perf_reads,
  output logic [31:0]       perf_writes,
  output logic [31:0]       perf_stall
`endif
);

  adapter_state_e     state_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  line_t              wdata_q, line_rdata_q;
  logic [ADDR_W-1:0]  mem_address_q;
  beat_t              mem_wdata_q;
  logic               mem_read_q, mem_write_q, line_resp_q;
  logic               last_beat;

  assign cnt_d     = cnt_q + 1'b1;
  assign last_beat = mem_resp && (cnt_q == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      wdata_q       <= '0;
      line_rdata_q  <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      line_resp_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          // Writeback takes priority over fill; a held read is taken next IDLE.
          if (line_write) begin
            mem_address_q <= line_align(line_address);
            wdata_q       <= line_wdata;
            mem_wdata_q   <= line_wdata[BEAT_W-1:0];
            mem_write_q   <= 1'b1;
            state_q       <= ST_WRITE;
          end else if (line_read) begin
            mem_address_q <= line_align(line_address);
            mem_read_q    <= 1'b1;
            state_q       <= ST_READ;
          end
        end
        ST_READ: begin
          if (mem_resp) begin
            line_rdata_q[{cnt_q, {BEAT_SH{1'b0}}} +: BEAT_W] <= mem_rdata;
            cnt_q <= cnt_d;
            if (last_beat) begin
              mem_read_q  <= 1'b0;
              line_resp_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_WRITE: begin
          if (mem_resp) begin
            cnt_q       <= cnt_d;
            mem_wdata_q <= wdata_q[{cnt_d, {BEAT_SH{1'b0}}} +: BEAT_W];
            if (last_beat) begin
              mem_write_q <= 1'b0;
              line_resp_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          line_resp_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign line_rdata  = line_rdata_q;
  assign line_resp   = line_resp_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

`ifdef CACHELINE_ADAPTER_PERF_EN
  logic rd_done, wr_done, stall;

  assign rd_done = (state_q == ST_READ)  && last_beat;
  assign wr_done = (state_q == ST_WRITE) && last_beat;
  assign stall   = (mem_read_q || mem_write_q) && !mem_resp;

  cacheline_adapter_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .rd_done_i    (rd_done),
    .wr_done_i    (wr_done),
    .stall_i      (stall),
    .perf_reads_o (perf_reads),
    .perf_writes_o(perf_writes),
    .perf_stall_o (perf_stall)
  );
`endif

endmodule
